// File: rtl/rgb_to_hsv.sv
// RGB to HSV converter: one triple in flight, a shared restoring divider
// computes saturation and then the hue term, one quotient bit per cycle.
//   state | meaning
//   IDLE  | ready for a triple
//   SETUP | max/min/delta and hue sector
//   DIV_S | delta<<F / max
//   DIV_H | 60*|d|<<F / delta
//   DONE  | present result until consumed
module rgb_to_hsv #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DATA_WIDTH-1:0]            data_in1,
    input  logic [DATA_WIDTH-1:0]            data_in2,
    input  logic [DATA_WIDTH-1:0]            data_in3,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [9+FRAC_WIDTH-1:0]          data_out1,
    output logic [DATA_WIDTH+FRAC_WIDTH-1:0] data_out2,
    output logic [DATA_WIDTH+FRAC_WIDTH-1:0] data_out3,
    output logic                             out_valid,
    input  logic                             out_ready
);
    localparam int DW = DATA_WIDTH;
    localparam int QW = 9 + FRAC_WIDTH;
    localparam int WD = QW + DW;
    localparam int SW = DW + FRAC_WIDTH;
    localparam int CW = $clog2(QW);
    localparam logic [QW-1:0] H120 = QW'(120 * (1 << FRAC_WIDTH));
    localparam logic [QW-1:0] H240 = QW'(240 * (1 << FRAC_WIDTH));
    localparam logic [QW-1:0] H360 = QW'(360 * (1 << FRAC_WIDTH));

    typedef enum logic [2:0] {IDLE, SETUP, DIV_S, DIV_H, DONE} state_t;
    typedef enum logic [1:0] {SEC_R, SEC_G, SEC_B} sector_t;

    state_t            state_q, state_d;
    sector_t           sector_q, sector_c;
    logic [DW-1:0]     r_q, g_q, b_q;
    logic [DW-1:0]     max_q, delta_q, absd_q;
    logic              d_neg_q;
    logic [DW-1:0]     max_c, min_c, delta_c, pa, pb, absd_c;
    logic              d_neg_c;
    logic [WD-1:0]     s_wide, h_wide;
    logic [DW-1:0]     rem_q, rem_nx, divisor;
    logic [QW-1:0]     dvd_q, quo_q, quo_nx, s_q, h_c;
    logic [DW:0]       trial;
    logic              ge;
    logic [CW-1:0]     cnt_q;

    assign in_ready = (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SETUP;
            SETUP:   state_d = DIV_S;
            DIV_S:   if (cnt_q == '0) state_d = DIV_H;
            DIV_H:   if (cnt_q == '0) state_d = DONE;
            DONE:    if (out_valid && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sector by max with R, G, B priority; pa-pb is the sector's signed d.
    always_comb begin
        sector_c = SEC_R;
        max_c    = r_q;
        pa       = g_q;
        pb       = b_q;
        if (r_q >= g_q && r_q >= b_q) begin
            sector_c = SEC_R; max_c = r_q; pa = g_q; pb = b_q;
        end else if (g_q >= b_q) begin
            sector_c = SEC_G; max_c = g_q; pa = b_q; pb = r_q;
        end else begin
            sector_c = SEC_B; max_c = b_q; pa = r_q; pb = g_q;
        end
        min_c = r_q;
        if (g_q < min_c) min_c = g_q;
        if (b_q < min_c) min_c = b_q;
        delta_c = max_c - min_c;
        d_neg_c = (pa < pb);
        absd_c  = d_neg_c ? (pb - pa) : (pa - pb);
        s_wide  = {{(WD-DW-FRAC_WIDTH){1'b0}}, delta_c, {FRAC_WIDTH{1'b0}}};
        h_wide  = (WD'(absd_q) * WD'(60)) << FRAC_WIDTH;
    end

    // Quotients never exceed QW bits, so the dividend's top bits seed the remainder.
    always_comb begin
        divisor = (state_q == DIV_S) ? max_q : delta_q;
        trial   = {rem_q, dvd_q[QW-1]};
        ge      = (trial >= {1'b0, divisor});
        rem_nx  = ge ? (trial[DW-1:0] - divisor) : trial[DW-1:0];
        quo_nx  = {quo_q[QW-2:0], ge};
    end

    always_comb begin
        case (sector_q)
            SEC_R:   h_c = d_neg_q ? (H360 - quo_q) : quo_q;
            SEC_G:   h_c = d_neg_q ? (H120 - quo_q) : (H120 + quo_q);
            default: h_c = d_neg_q ? (H240 - quo_q) : (H240 + quo_q);
        endcase
        if (delta_q == '0) h_c = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0; g_q <= '0; b_q <= '0;
            max_q <= '0; delta_q <= '0; absd_q <= '0; d_neg_q <= 1'b0;
            sector_q <= SEC_R;
            rem_q <= '0; dvd_q <= '0; quo_q <= '0; s_q <= '0; cnt_q <= '0;
            data_out1 <= '0; data_out2 <= '0; data_out3 <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        r_q <= data_in1; g_q <= data_in2; b_q <= data_in3;
                    end
                end
                SETUP: begin
                    max_q    <= max_c;
                    delta_q  <= delta_c;
                    sector_q <= sector_c;
                    d_neg_q  <= d_neg_c;
                    absd_q   <= absd_c;
                    rem_q    <= s_wide[WD-1:QW];
                    dvd_q    <= s_wide[QW-1:0];
                    quo_q    <= '0;
                    cnt_q    <= CW'(QW - 1);
                end
                DIV_S: begin
                    if (cnt_q == '0) begin
                        s_q   <= (max_q == '0) ? '0 : quo_nx;
                        rem_q <= h_wide[WD-1:QW];
                        dvd_q <= h_wide[QW-1:0];
                        quo_q <= '0;
                        cnt_q <= CW'(QW - 1);
                    end else begin
                        rem_q <= rem_nx;
                        dvd_q <= dvd_q << 1;
                        quo_q <= quo_nx;
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DIV_H: begin
                    rem_q <= rem_nx;
                    dvd_q <= dvd_q << 1;
                    quo_q <= quo_nx;
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                DONE: begin
                    if (!out_valid) begin
                        data_out1 <= h_c;
                        data_out2 <= SW'(s_q);
                        data_out3 <= {max_q, {FRAC_WIDTH{1'b0}}};
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rgb_to_hsv.sv
// Scoreboard bench for rgb_to_hsv: driver pushes hand-computed results,
// monitor pops and compares on each out_valid rise, including latency.
module tb_rgb_to_hsv;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data_in1, data_in2, data_in3;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [16:0] data_out1;
    logic [15:0] data_out2, data_out3;

    rgb_to_hsv #(.DATA_WIDTH(8), .FRAC_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] h;
        logic [15:0] s;
        logic [15:0] v;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_out = 0;
    logic ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && !ov_prev) begin
            exp_t e;
            n_out++;
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'(n_out), 32'(n_out - 1));
            end else begin
                e = exp_q.pop_front();
                chk("latency", 32'(cyc - e.acc), 32'd36);
                chk("hue", 32'(data_out1), 32'(e.h));
                chk("sat", 32'(data_out2), 32'(e.s));
                chk("val", 32'(data_out3), 32'(e.v));
            end
        end
        ov_prev = out_valid;
    end

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic [16:0] eh, input logic [15:0] es, input logic [15:0] ev,
                        input bit push);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        data_in1 = r; data_in2 = g; data_in3 = b;
        in_valid = 1'b1;
        if (push) exp_q.push_back('{eh, es, ev, cyc + 1});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < 200), 32'd1);
    endtask

    initial begin
        logic [16:0] h0;
        logic [15:0] s0, v0;
        int          outs_before;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        data_in1 = '0; data_in2 = '0; data_in3 = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outs", {15'd0, data_out1} | 32'(data_out2) | 32'(data_out3), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        send(8'd255, 8'd0,   8'd0,   17'h00000, 16'h0100, 16'hFF00, 1); drain();
        send(8'd0,   8'd255, 8'd0,   17'h07800, 16'h0100, 16'hFF00, 1); drain();
        send(8'd0,   8'd0,   8'd255, 17'h0F000, 16'h0100, 16'hFF00, 1); drain();
        send(8'd200, 8'd100, 8'd50,  17'h01400, 16'h00C0, 16'hC800, 1); drain();
        send(8'd128, 8'd128, 8'd128, 17'h00000, 16'h0000, 16'h8000, 1); drain();
        send(8'd0,   8'd0,   8'd0,   17'h00000, 16'h0000, 16'h0000, 1); drain();
        send(8'd50,  8'd100, 8'd200, 17'h0DC00, 16'h00C0, 16'hC800, 1); drain();
        send(8'd100, 8'd200, 8'd50,  17'h06400, 16'h00C0, 16'hC800, 1); drain();
        send(8'd10,  8'd7,   8'd3,   17'h02249, 16'h00B3, 16'h0A00, 1); drain();

        // Hold with out_ready low, then release.
        out_ready = 1'b0;
        send(8'd255, 8'd0, 8'd255, 17'h12C00, 16'h0100, 16'hFF00, 1);
        begin
            int n = 0;
            while (!out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("hold_reached", 32'(out_valid), 32'd1);
        h0 = data_out1; s0 = data_out2; v0 = data_out3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_busy", 32'(in_ready), 32'd0);
            chk("hold_data", {15'd0, data_out1} ^ 32'(data_out2 ^ s0) ^ 32'(data_out3 ^ v0),
                {15'd0, h0});
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_ready", 32'(in_ready), 32'd1);

        // in_valid pulsed mid-division must be ignored.
        outs_before = n_out;
        send(8'd0, 8'd255, 8'd0, 17'h07800, 16'h0100, 16'hFF00, 1);
        repeat (10) @(negedge clk);
        data_in1 = 8'd10; data_in2 = 8'd20; data_in3 = 8'd30;
        in_valid = 1'b1;
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        drain();
        repeat (40) @(negedge clk);
        chk("ignore_outputs", 32'(n_out - outs_before), 32'd1);

        // Reset during DIV_H aborts with no output.
        outs_before = n_out;
        send(8'd255, 8'd0, 8'd0, 17'h0, 16'h0, 16'h0, 0);
        repeat (25) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        chk("abort_no_output", 32'(n_out - outs_before), 32'd0);
        send(8'd200, 8'd100, 8'd50, 17'h01400, 16'h00C0, 16'hC800, 1); drain();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
